fc_layer_sched: RTL and testbench
=================================

Name: fc_layer_sched

Overview:
- Sequencer for the fully-connected output layer that follows the LSTM.
- Walks the hidden-state buffer (HIDDEN_SIZE entries) and the FC weight ROM (HIDDEN_SIZE*OUTPUT_SIZE entries).
- Issues one (ht, weight, output-index) operand pair per cycle to the shared 24x8 multiply-accumulate datapath.
- Raises frame_done once the last product has left the multiplier pipeline.

Parameters:
- QZ, 24, hidden-state word width
- QZ_D, 8, weight word width
- OUTPUT_SIZE, 2, FC outputs per hidden element
- HIDDEN_SIZE, 512, hidden elements per frame
- MULT_LAT, 5, multiplier pipeline latency in cycles
- HS_W, $clog2(HIDDEN_SIZE)+1, hidden index width
- OS_W, $clog2(OUTPUT_SIZE)+1, output index width
- WA_W, $clog2(HIDDEN_SIZE*OUTPUT_SIZE)+1, weight address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame start request
- busy  out  1  high from the cycle after an accepted start until frame_done
- ht_rd_en  out  1  hidden buffer read strobe
- ht_rd_adr  out  HS_W  hidden buffer address
- ht_rd_data  in  QZ  read data, valid 1 cycle after ht_rd_en
- w_rd_en  out  1  weight ROM read strobe
- w_rd_adr  out  WA_W  weight address = hs*OUTPUT_SIZE+os
- w_rd_data  in  QZ_D  ROM data, valid 1 cycle after w_rd_en
- mac_ready  in  1  datapath permits a new issue this cycle
- mac_valid  out  1  operand pair valid
- mac_ht  out  QZ  hidden operand
- mac_w  out  QZ_D  weight operand
- mac_os  out  OS_W  accumulator select
- mac_first  out  1  first pair of the frame for this mac_os; accumulator clears
- mac_last  out  1  final pair of the frame (hs=HIDDEN_SIZE-1, os=OUTPUT_SIZE-1)
- frame_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; state IDLE; hs=0, os=0, drain counter 0.
- IDLE:
  - start=1 -> FETCH.
  - busy rises next cycle.
- FETCH:
  - ht_rd_en=1 for one cycle with ht_rd_adr=hs.
  - Next state LATCH.
- LATCH:
  - ht_reg <= ht_rd_data.
  - os <= 0.
  - Next state ISSUE.
- ISSUE:
  - Each cycle with mac_ready=1: w_rd_en=1, w_rd_adr=hs*OUTPUT_SIZE+os, os increments.
  - mac_ready=0: no read issued, state holds, os and addresses hold.
  - After the issue with os=OUTPUT_SIZE-1:
    - hs<HIDDEN_SIZE-1 -> hs+1, FETCH.
    - otherwise -> DRAIN, hs wraps to 0.
- Operand stage:
  - mac_valid is asserted exactly 1 cycle after each w_rd_en.
  - mac_ht=ht_reg, mac_w=w_rd_data, mac_os, mac_first and mac_last registered from the issuing cycle.
  - mac_valid is never held; one pair already in flight when mac_ready drops is still delivered (datapath provides a 1-deep skid).
  - mac_ht/mac_w hold their last values while mac_valid=0.
- DRAIN:
  - Counter loads MULT_LAT on the last mac_valid and decrements.
  - At 0: frame_done=1 for one cycle, busy=0 in the same cycle, state IDLE.
  - frame_done therefore occurs MULT_LAT cycles after the mac_last cycle.
- Throughput: (2+OUTPUT_SIZE) cycles per hidden element without back-pressure.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as frame_done is also ignored.
- A new start is accepted the cycle after frame_done.
- rst_n asserted mid-frame: immediate return to reset values, no frame_done, in-flight mac_valid dropped.
- Address arithmetic is unsigned with no wrap within a frame; the maximum w_rd_adr is HIDDEN_SIZE*OUTPUT_SIZE-1.

Optional Feature:
- FC_SCHED_ABORT_EN defined: adds input abort (1) and output frame_aborted (1).
  - abort=1 in any non-IDLE state -> IDLE next cycle.
  - Pending mac_valid is suppressed; hs, os and counters clear.
  - frame_aborted pulses 1 cycle; no frame_done is issued.
  - abort in IDLE has no effect.
- FC_SCHED_ABORT_EN undefined: ports absent; a frame always runs to frame_done or reset.

Test Plan:
- Bench parameters: HIDDEN_SIZE=4, OUTPUT_SIZE=2, MULT_LAT=5.
- Reset: hold rst_n=0 with random inputs -> all outputs 0; after release, outputs stay 0 with no start.
- Normal frame, mac_ready=1:
  - ht_rd_adr sequence 0,1,2,3; w_rd_adr 0..7 in order.
  - 8 mac_valid with mac_os 0,1,0,1,...
  - mac_first on the first two pairs, mac_last on pair 8.
  - frame_done 5 cycles after mac_last; 16 cycles from start to last mac_valid.
- Back-pressure: mac_ready=0 for 3 cycles after w_rd_adr=2 issues -> no w_rd_en for 3 cycles, then 3,4,...; still exactly 8 mac_valid, data matches ROM model.
- start re-asserted at cycle 6 of a frame and again on the frame_done cycle -> both ignored; single frame_done; next start 1 cycle later accepted.
- rst_n low after 5 mac_valid -> outputs 0 immediately; a subsequent start runs a clean full frame from address 0.
- FC_SCHED_ABORT_EN: abort on the 3rd mac_valid cycle -> no further mac_valid, frame_aborted pulse, no frame_done, busy=0 next cycle.

Source files
------------

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: feeds (ht, weight, os) operand pairs to the shared 24x8 MAC.
// Define FC_SCHED_ABORT_EN to add the i_abort / o_frame_aborted pair.
module fc_layer_sched #(
   parameter int QZ          = 24,
   parameter int QZ_D        = 8,
   parameter int OUTPUT_SIZE = 2,
   parameter int HIDDEN_SIZE = 512,
   parameter int MULT_LAT    = 5,
   parameter int HS_W        = $clog2(HIDDEN_SIZE) + 1,
   parameter int OS_W        = $clog2(OUTPUT_SIZE) + 1,
   parameter int WA_W        = $clog2(HIDDEN_SIZE * OUTPUT_SIZE) + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
`ifdef FC_SCHED_ABORT_EN
   input  logic            i_abort,
   output logic            o_frame_aborted,
`endif
   output logic            o_busy,
   output logic            o_ht_rd_en,
   output logic [HS_W-1:0] o_ht_rd_adr,
   input  logic [QZ-1:0]   i_ht_rd_data,
   output logic            o_w_rd_en,
   output logic [WA_W-1:0] o_w_rd_adr,
   input  logic [QZ_D-1:0] i_w_rd_data,
   input  logic            i_mac_ready,
   output logic            o_mac_valid,
   output logic [QZ-1:0]   o_mac_ht,
   output logic [QZ_D-1:0] o_mac_w,
   output logic [OS_W-1:0] o_mac_os,
   output logic            o_mac_first,
   output logic            o_mac_last,
   output logic            o_frame_done
);

   localparam int CW = $clog2(MULT_LAT + 1) + 1;

   localparam logic [HS_W-1:0] HS_LAST  = HS_W'(HIDDEN_SIZE - 1);
   localparam logic [HS_W-1:0] HS_ONE   = HS_W'(1);
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OUTPUT_SIZE - 1);
   localparam logic [OS_W-1:0] OS_ONE   = OS_W'(1);
   localparam logic [WA_W-1:0] WA_ONE   = WA_W'(1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'((MULT_LAT > 1) ? MULT_LAT - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t          r_state;
   logic            r_busy;
   logic [HS_W-1:0] r_hs;
   logic [OS_W-1:0] r_os;
   logic [WA_W-1:0] r_wadr;
   logic [CW-1:0]   r_cnt;
   logic [QZ-1:0]   r_ht;
   logic            r_mac_valid;
   logic [QZ-1:0]   r_mac_ht;
   logic [OS_W-1:0] r_mac_os;
   logic            r_mac_first;
   logic            r_mac_last;
   logic [QZ_D-1:0] r_w_hold;
   logic            r_frame_done;
`ifdef FC_SCHED_ABORT_EN
   logic            r_frame_aborted;
`endif

   logic w_abort;
   logic w_issue;
   logic w_os_end;
   logic w_hs_end;

`ifdef FC_SCHED_ABORT_EN
   assign w_abort = i_abort && (r_state != S_IDLE);
`else
   assign w_abort = 1'b0;
`endif

   // an abort wins over a ready issue so no operand escapes after it
   assign w_issue  = (r_state == S_ISSUE) && i_mac_ready && !w_abort;
   assign w_os_end = (r_os == OS_LAST);
   assign w_hs_end = (r_hs == HS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_hs         <= '0;
         r_os         <= '0;
         r_wadr       <= '0;
         r_cnt        <= '0;
         r_ht         <= '0;
         r_mac_valid  <= 1'b0;
         r_mac_ht     <= '0;
         r_mac_os     <= '0;
         r_mac_first  <= 1'b0;
         r_mac_last   <= 1'b0;
         r_w_hold     <= '0;
         r_frame_done <= 1'b0;
`ifdef FC_SCHED_ABORT_EN
         r_frame_aborted <= 1'b0;
`endif
      end else begin
         if (r_mac_valid) begin
            r_w_hold <= i_w_rd_data;
         end
         if (w_abort) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_hs         <= '0;
            r_os         <= '0;
            r_wadr       <= '0;
            r_cnt        <= '0;
            r_mac_valid  <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef FC_SCHED_ABORT_EN
            r_frame_aborted <= 1'b1;
`endif
         end else begin
            r_frame_done <= 1'b0;
`ifdef FC_SCHED_ABORT_EN
            r_frame_aborted <= 1'b0;
`endif
            r_mac_valid <= w_issue;
            if (w_issue) begin
               r_mac_ht    <= r_ht;
               r_mac_os    <= r_os;
               r_mac_first <= (r_hs == '0);
               r_mac_last  <= w_hs_end && w_os_end;
            end
            unique case (r_state)
               S_IDLE: begin
                  // the cycle of frame_done itself never accepts a start
                  if (i_start && !r_frame_done) begin
                     r_state <= S_FETCH;
                     r_busy  <= 1'b1;
                  end
               end
               S_FETCH: begin
                  r_state <= S_LATCH;
               end
               S_LATCH: begin
                  r_ht    <= i_ht_rd_data;
                  r_os    <= '0;
                  r_state <= S_ISSUE;
               end
               S_ISSUE: begin
                  if (w_issue) begin
                     if (w_os_end) begin
                        r_os <= '0;
                        if (w_hs_end) begin
                           r_hs    <= '0;
                           r_wadr  <= '0;
                           r_state <= S_DRAIN;
                        end else begin
                           r_hs    <= r_hs + HS_ONE;
                           r_wadr  <= r_wadr + WA_ONE;
                           r_state <= S_FETCH;
                        end
                     end else begin
                        r_os   <= r_os + OS_ONE;
                        r_wadr <= r_wadr + WA_ONE;
                     end
                  end
               end
               S_DRAIN: begin
                  if (r_mac_valid && r_mac_last) begin
                     if (MULT_LAT <= 1) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_cnt        <= '0;
                     end else begin
                        r_cnt <= CNT_LOAD;
                     end
                  end else if (r_cnt == CNT_ONE) begin
                     r_state      <= S_IDLE;
                     r_busy       <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_cnt        <= '0;
                  end else if (r_cnt != '0) begin
                     r_cnt <= r_cnt - CNT_ONE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign o_busy       = r_busy;
   assign o_ht_rd_en   = (r_state == S_FETCH);
   assign o_ht_rd_adr  = r_hs;
   assign o_w_rd_en    = w_issue;
   assign o_w_rd_adr   = r_wadr;
   assign o_mac_valid  = r_mac_valid;
   assign o_mac_ht     = r_mac_ht;
   assign o_mac_w      = r_mac_valid ? i_w_rd_data : r_w_hold;
   assign o_mac_os     = r_mac_os;
   assign o_mac_first  = r_mac_first;
   assign o_mac_last   = r_mac_last;
   assign o_frame_done = r_frame_done;
`ifdef FC_SCHED_ABORT_EN
   assign o_frame_aborted = r_frame_aborted;
`endif

endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: scoreboard bench for fc_layer_sched (HIDDEN_SIZE=4).
// Also exercises the abort pair when FC_SCHED_ABORT_EN is defined.
module tb_fc_layer_sched;

   localparam int QZ   = 24;
   localparam int QZ_D = 8;
   localparam int OS   = 2;
   localparam int HS   = 4;
   localparam int ML   = 5;
   localparam int HS_W = $clog2(HS) + 1;
   localparam int OS_W = $clog2(OS) + 1;
   localparam int WA_W = $clog2(HS * OS) + 1;
`ifdef FC_SCHED_ABORT_EN
   localparam int AOW = 1 + 1 + HS_W + 1 + WA_W + 1 + QZ + QZ_D + OS_W + 4;
`else
   localparam int AOW = 1 + 1 + HS_W + 1 + WA_W + 1 + QZ + QZ_D + OS_W + 3;
`endif

   typedef struct packed {
      logic [QZ-1:0]   ht;
      logic [QZ_D-1:0] w;
      logic [OS_W-1:0] os;
      logic            first;
      logic            last;
   } pair_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            busy;
   logic            ht_rd_en;
   logic [HS_W-1:0] ht_rd_adr;
   logic [QZ-1:0]   ht_rd_data;
   logic            w_rd_en;
   logic [WA_W-1:0] w_rd_adr;
   logic [QZ_D-1:0] w_rd_data;
   logic            mac_ready = 1'b1;
   logic            mac_valid;
   logic [QZ-1:0]   mac_ht;
   logic [QZ_D-1:0] mac_w;
   logic [OS_W-1:0] mac_os;
   logic            mac_first;
   logic            mac_last;
   logic            frame_done;
`ifdef FC_SCHED_ABORT_EN
   logic            abort = 1'b0;
   logic            frame_aborted;
`endif

   logic [QZ-1:0]   ht_mem [HS];
   logic [QZ_D-1:0] w_mem [HS*OS];
   logic [QZ-1:0]   mem_ht_q = '0;
   logic [QZ_D-1:0] mem_w_q = '0;
   logic            noise = 1'b0;
   logic [QZ-1:0]   noise_ht = '0;
   logic [QZ_D-1:0] noise_w = '0;
   logic [AOW-1:0]  all_out;

   pair_t sbq[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    n_valid = 0;
   int    n_done = 0;
   int    rise_cyc = 0;
   int    last_cyc = 0;
   int    done_cyc = 0;
   int    exp_wadr = 0;
   int    exp_hadr = 0;
   logic  done_busy = 1'b0;
   logic  busy_q = 1'b0;
   logic  have_w = 1'b0;
   logic [QZ_D-1:0] last_w = '0;

   always #5 clk = ~clk;

   fc_layer_sched #(
      .QZ(QZ), .QZ_D(QZ_D), .OUTPUT_SIZE(OS), .HIDDEN_SIZE(HS),
      .MULT_LAT(ML), .HS_W(HS_W), .OS_W(OS_W), .WA_W(WA_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_start(start),
`ifdef FC_SCHED_ABORT_EN
      .i_abort(abort),
      .o_frame_aborted(frame_aborted),
`endif
      .o_busy(busy),
      .o_ht_rd_en(ht_rd_en),
      .o_ht_rd_adr(ht_rd_adr),
      .i_ht_rd_data(ht_rd_data),
      .o_w_rd_en(w_rd_en),
      .o_w_rd_adr(w_rd_adr),
      .i_w_rd_data(w_rd_data),
      .i_mac_ready(mac_ready),
      .o_mac_valid(mac_valid),
      .o_mac_ht(mac_ht),
      .o_mac_w(mac_w),
      .o_mac_os(mac_os),
      .o_mac_first(mac_first),
      .o_mac_last(mac_last),
      .o_frame_done(frame_done)
   );

   // one-cycle-latency hidden buffer and weight ROM
   always @(posedge clk) begin
      if (ht_rd_en) mem_ht_q <= ht_mem[ht_rd_adr[HS_W-2:0]];
      if (w_rd_en) mem_w_q <= w_mem[w_rd_adr[WA_W-2:0]];
   end

   assign ht_rd_data = noise ? noise_ht : mem_ht_q;
   assign w_rd_data  = noise ? noise_w : mem_w_q;

`ifdef FC_SCHED_ABORT_EN
   assign all_out = {busy, ht_rd_en, ht_rd_adr, w_rd_en, w_rd_adr, mac_valid,
                     mac_ht, mac_w, mac_os, mac_first, mac_last, frame_done,
                     frame_aborted};
`else
   assign all_out = {busy, ht_rd_en, ht_rd_adr, w_rd_en, w_rd_adr, mac_valid,
                     mac_ht, mac_w, mac_os, mac_first, mac_last, frame_done};
`endif

   task automatic scoreboard();
      pair_t e;
      pair_t a;
      logic [HS_W-2:0] hi;
      logic [WA_W-2:0] wi;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) have_w = 1'b0;
         if (busy && !busy_q) rise_cyc = cyc;
         busy_q = busy;
         if (ht_rd_en) begin
            checks++;
            if (ht_rd_adr !== HS_W'(exp_hadr)) begin
               errors++;
               $display("FAIL ht_rd_adr: got %0d want %0d", ht_rd_adr, exp_hadr);
            end
            exp_hadr = (exp_hadr + 1) % HS;
         end
         if (w_rd_en) begin
            checks++;
            if (w_rd_adr !== WA_W'(exp_wadr)) begin
               errors++;
               $display("FAIL w_rd_adr: got %0d want %0d", w_rd_adr, exp_wadr);
            end
            hi = (HS_W-1)'(exp_wadr / OS);
            wi = (WA_W-1)'(exp_wadr);
            e.ht    = ht_mem[hi];
            e.w     = w_mem[wi];
            e.os    = OS_W'(exp_wadr % OS);
            e.first = (exp_wadr / OS == 0);
            e.last  = (exp_wadr == HS * OS - 1);
            sbq.push_back(e);
            exp_wadr = (exp_wadr + 1) % (HS * OS);
         end
         if (mac_valid) begin
            n_valid++;
            checks++;
            a = {mac_ht, mac_w, mac_os, mac_first, mac_last};
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL mac_pair: got %h with nothing expected", a);
            end else begin
               e = sbq.pop_front();
               if (a !== e) begin
                  errors++;
                  $display("FAIL mac_pair: got %h want %h", a, e);
               end
            end
            if (mac_last) last_cyc = cyc;
            last_w = mac_w;
            have_w = 1'b1;
         end else if (have_w) begin
            checks++;
            if (mac_w !== last_w) begin
               errors++;
               $display("FAIL mac_w_hold: got %h want %h", mac_w, last_w);
            end
         end
         if (frame_done) begin
            n_done++;
            done_cyc = cyc;
            done_busy = busy;
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (n_done >= target) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      noise = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         start     = 1'($urandom);
         mac_ready = 1'($urandom);
         noise_ht  = QZ'($urandom);
         noise_w   = QZ_D'($urandom);
`ifdef FC_SCHED_ABORT_EN
         abort     = 1'($urandom);
`endif
         @(negedge clk);
         #1;
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
         end
      end
      noise     = 1'b0;
      start     = 1'b0;
      mac_ready = 1'b1;
`ifdef FC_SCHED_ABORT_EN
      abort     = 1'b0;
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL idle_outputs: got %h want 0", all_out);
         end
      end
   endtask

   task automatic test_normal();
      bit ok;
      n_valid = 0;
      n_done  = 0;
      pulse_start();
      wait_done(1, 80, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL normal_timeout: got no frame_done want 1");
      end
      repeat (8) @(negedge clk);
      checks++;
      if (n_valid != HS * OS) begin
         errors++;
         $display("FAIL normal_count: got %0d want %0d", n_valid, HS * OS);
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL normal_done_count: got %0d want 1", n_done);
      end
      checks++;
      if (last_cyc - rise_cyc != (2 + OS) * HS) begin
         errors++;
         $display("FAIL normal_latency: got %0d want %0d", last_cyc - rise_cyc, (2 + OS) * HS);
      end
      checks++;
      if (done_cyc - last_cyc != ML) begin
         errors++;
         $display("FAIL normal_drain: got %0d want %0d", done_cyc - last_cyc, ML);
      end
      checks++;
      if (done_busy !== 1'b0) begin
         errors++;
         $display("FAIL normal_busy_at_done: got %b want 0", done_busy);
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL normal_leftover: got %0d want 0", sbq.size());
      end
   endtask

   task automatic test_back_pressure();
      bit ok;
      n_valid = 0;
      n_done  = 0;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (w_rd_en && w_rd_adr == WA_W'(2)) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_find_adr2: got none want issue");
      end
      @(posedge clk);
      #1 mac_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (w_rd_en !== 1'b0 || w_rd_adr !== WA_W'(3)) begin
            errors++;
            $display("FAIL bp_stall: got en=%b adr=%0d want en=0 adr=3", w_rd_en, w_rd_adr);
         end
      end
      @(posedge clk);
      #1 mac_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (w_rd_en !== 1'b1 || w_rd_adr !== WA_W'(3)) begin
         errors++;
         $display("FAIL bp_resume: got en=%b adr=%0d want en=1 adr=3", w_rd_en, w_rd_adr);
      end
      wait_done(1, 80, ok);
      repeat (8) @(negedge clk);
      checks++;
      if (!ok || n_done != 1 || n_valid != HS * OS) begin
         errors++;
         $display("FAIL bp_frame: got done=%0d valid=%0d want 1 %0d", n_done, n_valid, HS * OS);
      end
      checks++;
      if (last_cyc - rise_cyc != (2 + OS) * HS + 3) begin
         errors++;
         $display("FAIL bp_latency: got %0d want %0d", last_cyc - rise_cyc, (2 + OS) * HS + 3);
      end
   endtask

   task automatic test_restart_ignore();
      bit ok;
      n_valid = 0;
      n_done  = 0;
      pulse_start();
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (frame_done) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL restart_timeout: got no frame_done want 1");
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL restart_done_cycle: got busy=%b want 0", busy);
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL restart_accept: got busy=%b want 1", busy);
      end
      checks++;
      if (n_done != 1 || done_cyc - last_cyc != ML) begin
         errors++;
         $display("FAIL restart_first: got done=%0d gap=%0d want 1 %0d", n_done, done_cyc - last_cyc, ML);
      end
      wait_done(2, 80, ok);
      repeat (8) @(negedge clk);
      checks++;
      if (!ok || n_done != 2 || n_valid != 2 * HS * OS) begin
         errors++;
         $display("FAIL restart_second: got done=%0d valid=%0d want 2 %0d", n_done, n_valid, 2 * HS * OS);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      n_valid = 0;
      n_done  = 0;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (n_valid >= 5) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rstmid_timeout: got %0d valid want 5", n_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL rstmid_immediate: got %h want 0", all_out);
      end
      sbq.delete();
      exp_wadr = 0;
      exp_hadr = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (all_out !== '0) begin
            errors++;
            $display("FAIL rstmid_hold: got %h want 0", all_out);
         end
      end
      rst_n = 1'b1;
      checks++;
      if (n_done != 0) begin
         errors++;
         $display("FAIL rstmid_no_done: got %0d want 0", n_done);
      end
      n_valid = 0;
      pulse_start();
      wait_done(1, 80, ok);
      repeat (8) @(negedge clk);
      checks++;
      if (!ok || n_done != 1 || n_valid != HS * OS || sbq.size() != 0) begin
         errors++;
         $display("FAIL rstmid_clean: got done=%0d valid=%0d left=%0d want 1 %0d 0",
                  n_done, n_valid, sbq.size(), HS * OS);
      end
   endtask

`ifdef FC_SCHED_ABORT_EN
   task automatic test_abort();
      bit ok;
      n_valid = 0;
      n_done  = 0;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         #1;
         if (n_valid >= 3) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL abort_timeout: got %0d valid want 3", n_valid);
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      sbq.delete();
      exp_wadr = 0;
      exp_hadr = 0;
      @(negedge clk);
      #1;
      checks++;
      if (frame_aborted !== 1'b1 || busy !== 1'b0 || mac_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_pulse: got ab=%b busy=%b v=%b want 1 0 0", frame_aborted, busy, mac_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (frame_aborted !== 1'b0) begin
         errors++;
         $display("FAIL abort_one_cycle: got %b want 0", frame_aborted);
      end
      repeat (12) @(negedge clk);
      checks++;
      if (n_valid != 3 || n_done != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_quiet: got valid=%0d done=%0d busy=%b want 3 0 0", n_valid, n_done, busy);
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < HS; i++) ht_mem[i] = QZ'($urandom);
      for (int i = 0; i < HS * OS; i++) w_mem[i] = QZ_D'($urandom);
      fork
         scoreboard();
      join_none
      test_reset();
      test_normal();
      test_back_pressure();
      test_restart_ignore();
      test_reset_mid();
`ifdef FC_SCHED_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
